// File: rtl/ttt_pkg.sv
// Shared types and constant tables for the tic-tac-toe board controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P2    = 2'b01,
    P1    = 2'b10,
    DRAW  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  localparam logic [15:0] COL_EDGE [0:3] = '{16'd0, 16'd213, 16'd426, 16'd640};
  localparam logic [9:0]  ROW_EDGE [0:3] = '{10'd0, 10'd160, 10'd320, 10'd480};

  localparam logic [3:0] WIN_LINES [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_col(input logic [3:0] c);
    return 2'(c % 4'd3);
  endfunction

  function automatic logic [1:0] cell_row(input logic [3:0] c);
    return 2'(c / 4'd3);
  endfunction

endpackage

// File: rtl/ttt_board_controller_btn_pulse.sv
// Two-flop synchroniser plus edge flop; one-cycle pulse per rising edge of btn.
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], btn};
  end

  assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/ttt_board_controller.sv
// Tic-tac-toe game state: cursor, marks, turn, win/draw detection, cursor cell bounds.
// Optional per-turn auto-placement timeout under `TTT_TURN_TIMEOUT_EN.
module ttt_board_controller
  import ttt_pkg::*;
#(
  parameter int TURN_CYCLES = 250000000,
  parameter int TIMER_W     = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_btn,
  input  logic        place_btn,
  output logic [1:0]  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
  output logic [15:0] selected_square_startX,
  output logic [15:0] selected_square_endX,
  output logic [9:0]  selected_square_startY,
  output logic [9:0]  selected_square_endY,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner
);

  logic move_p, place_p;

  btn_pulse u_move  (.clk(clk), .rst_n(rst_n), .btn(move_btn),  .pulse(move_p));
  btn_pulse u_place (.clk(clk), .rst_n(rst_n), .btn(place_btn), .pulse(place_p));

  state_t            state, state_nxt;
  logic [8:0][1:0]   cells, cells_nxt;
  logic [3:0]        cursor, cursor_nxt;
  logic              turn_nxt, over_nxt, win, full;
  logic [1:0]        winner_nxt;
  cell_t             mark;

`ifdef TTT_TURN_TIMEOUT_EN
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [3:0]         free_idx;
  logic               timeout;

  // >= also catches the cycle after a place pulse on an occupied cell pre-empted the timeout
  assign timeout = (state == PLAY) && !place_p && (timer >= TIMER_W'(TURN_CYCLES - 1));

  always_comb begin
    free_idx = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (cells[i] == EMPTY) free_idx = 4'(i);
  end

  always_comb begin
    timer_nxt = '0;
    if (state == PLAY && state_nxt == PLAY) timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else        timer <= timer_nxt;
  end
`endif

  always_comb begin
    mark = turn ? P2 : P1;
    win  = 1'b0;
    full = 1'b1;
    for (int l = 0; l < 8; l++)
      if (cells[WIN_LINES[l][0]] == mark && cells[WIN_LINES[l][1]] == mark &&
          cells[WIN_LINES[l][2]] == mark) win = 1'b1;
    for (int i = 0; i < 9; i++)
      if (cells[i] == EMPTY) full = 1'b0;
  end

  always_comb begin
    state_nxt  = state;
    cells_nxt  = cells;
    cursor_nxt = cursor;
    turn_nxt   = turn;
    winner_nxt = winner;
    over_nxt   = game_over;
    case (state)
      PLAY: begin
        if (place_p) begin
          // place takes priority; a simultaneous move is dropped even if the cell is taken
          if (cells[cursor] == EMPTY) begin
            cells_nxt[cursor] = mark;
            state_nxt         = CHECK;
          end
`ifdef TTT_TURN_TIMEOUT_EN
        end else if (timeout) begin
          cells_nxt[free_idx] = mark;
          state_nxt           = CHECK;
`endif
        end else if (move_p) begin
          cursor_nxt = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
        end
      end
      CHECK: begin
        if (win) begin
          winner_nxt = mark;
          over_nxt   = 1'b1;
          state_nxt  = DONE;
        end else if (full) begin
          winner_nxt = DRAW;
          over_nxt   = 1'b1;
          state_nxt  = DONE;
        end else begin
          turn_nxt  = ~turn;
          state_nxt = PLAY;
        end
      end
      DONE: begin
        if (place_p) begin
          cells_nxt  = '0;
          cursor_nxt = 4'd0;
          turn_nxt   = 1'b0;
          winner_nxt = EMPTY;
          over_nxt   = 1'b0;
          state_nxt  = PLAY;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= PLAY;
      cells                  <= '0;
      cursor                 <= 4'd0;
      turn                   <= 1'b0;
      winner                 <= EMPTY;
      game_over              <= 1'b0;
      selected_square_startX <= COL_EDGE[0];
      selected_square_endX   <= COL_EDGE[1];
      selected_square_startY <= ROW_EDGE[0];
      selected_square_endY   <= ROW_EDGE[1];
    end else begin
      state                  <= state_nxt;
      cells                  <= cells_nxt;
      cursor                 <= cursor_nxt;
      turn                   <= turn_nxt;
      winner                 <= winner_nxt;
      game_over              <= over_nxt;
      selected_square_startX <= COL_EDGE[cell_col(cursor_nxt)];
      selected_square_endX   <= COL_EDGE[cell_col(cursor_nxt) + 2'd1];
      selected_square_startY <= ROW_EDGE[cell_row(cursor_nxt)];
      selected_square_endY   <= ROW_EDGE[cell_row(cursor_nxt) + 2'd1];
    end
  end

  assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = cells;

endmodule

// File: tb/tb_ttt_board_controller.sv
// Scoreboard bench for ttt_board_controller: a game model predicts outputs per button press.
module tb_ttt_board_controller;

  logic clk = 1'b0, rst_n = 1'b0, move_btn = 1'b0, place_btn = 1'b0;
  logic [1:0]  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, winner;
  logic [15:0] sx, ex;
  logic [9:0]  sy, ey;
  logic        turn, game_over;

  ttt_board_controller #(.TURN_CYCLES(16), .TIMER_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .move_btn(move_btn), .place_btn(place_btn),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .selected_square_startX(sx), .selected_square_endX(ex),
    .selected_square_startY(sy), .selected_square_endY(ey),
    .turn(turn), .game_over(game_over), .winner(winner)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [17:0] board;
    logic [15:0] sx, ex;
    logic [9:0]  sy, ey;
    logic        turn, over;
    logic [1:0]  win;
  } snap_t;

  snap_t sb[$];
  int checks = 0, failures = 0;

  logic [1:0] mb [9];
  int         mcur;
  logic       mturn, mover;
  logic [1:0] mwin;
  int ce [4] = '{0, 213, 426, 640};
  int re [4] = '{0, 160, 320, 480};
  int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8},
                    '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < 9; i++) s.board[2*i +: 2] = mb[i];
    s.sx = 16'(ce[mcur % 3]); s.ex = 16'(ce[mcur % 3 + 1]);
    s.sy = 10'(re[mcur / 3]); s.ey = 10'(re[mcur / 3 + 1]);
    s.turn = mturn; s.over = mover; s.win = mwin;
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    mcur = 0; mturn = 1'b0; mover = 1'b0; mwin = 2'b00;
  endtask

  task automatic m_step(input bit mv, input bit pl);
    logic [1:0] mk;
    bit won, fl;
    if (mover) begin
      if (pl) m_reset();
    end else if (pl) begin
      if (mb[mcur] == 2'b00) begin
        mk = mturn ? 2'b01 : 2'b10;
        mb[mcur] = mk;
        won = 0; fl = 1;
        for (int l = 0; l < 8; l++)
          if (mb[ln[l][0]] == mk && mb[ln[l][1]] == mk && mb[ln[l][2]] == mk) won = 1;
        for (int i = 0; i < 9; i++) if (mb[i] == 2'b00) fl = 0;
        if (won)     begin mwin = mk;    mover = 1'b1; end
        else if (fl) begin mwin = 2'b11; mover = 1'b1; end
        else mturn = ~mturn;
      end
    end else if (mv) begin
      mcur = (mcur == 8) ? 0 : mcur + 1;
    end
  endtask

  task automatic compare(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_board"}, {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1}, e.board);
    chk({tag, "_sx"}, sx, e.sx);
    chk({tag, "_ex"}, ex, e.ex);
    chk({tag, "_sy"}, sy, e.sy);
    chk({tag, "_ey"}, ey, e.ey);
    chk({tag, "_turn"}, turn, e.turn);
    chk({tag, "_over"}, game_over, e.over);
    chk({tag, "_winner"}, winner, e.win);
  endtask

  task automatic press(input bit mv, input bit pl);
    @(negedge clk); move_btn = mv; place_btn = pl;
    repeat (4) @(negedge clk);
    move_btn = 1'b0; place_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic act(input bit mv, input bit pl, input string tag);
    m_step(mv, pl);
    sb.push_back(model_snap());
    press(mv, pl);
    compare(tag);
  endtask

  task automatic goto_cell(input int c);
    while (mcur != c) act(1, 0, "move");
  endtask

  task automatic place_at(input int c);
    goto_cell(c);
    act(0, 1, "place");
  endtask

  // Leaves the caller just after the edge at which the placement lands (FSM enters CHECK).
  task automatic timed_place();
    @(negedge clk); place_btn = 1'b1;
    @(posedge clk);
    @(negedge clk); place_btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst_n = 1'b0;
    m_reset();
    sb.push_back(model_snap());
    #1 compare(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int fill_order [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    m_reset();
    sb.push_back(model_snap());
    compare("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef TTT_TURN_TIMEOUT_EN
    m_step(0, 1);
    timed_place();
    repeat (16) @(posedge clk);
    @(negedge clk); chk("to_early_pos2", pos2, 2'b00);
    @(posedge clk);
    @(negedge clk); chk("to_pos2", pos2, 2'b01); chk("to_turn_chk", turn, 1'b1);
    chk("to_cursor_sx", sx, 16'd0);
    @(posedge clk);
    @(negedge clk); chk("to_turn", turn, 1'b0);
    repeat (17) @(posedge clk);
    @(negedge clk); chk("to2_pos3", pos3, 2'b10);
    rst_n = 1'b0;
    m_reset();
    sb.push_back(model_snap());
    #1 compare("to_rst_check");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`else
    // first-pulse latency and single pulse for a held button
    @(negedge clk); move_btn = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("lat_e0", sx, 16'd0);
    @(posedge clk);
    @(negedge clk); chk("lat_e1", sx, 16'd0);
    @(posedge clk);
    @(negedge clk); chk("lat_e2", sx, 16'd213);
    repeat (6) @(negedge clk);
    chk("held", sx, 16'd213);
    move_btn = 1'b0;
    repeat (4) @(negedge clk);
    m_step(1, 0);

    repeat (3) act(1, 0, "mv4");
    repeat (5) act(1, 0, "mv_wrap");
    repeat (9) act(1, 0, "mv9");

    // P1 wins on the top row
    place_at(0); place_at(3); place_at(1); place_at(4);
    goto_cell(2);
    m_step(0, 1);
    timed_place();
    @(negedge clk); chk("ovr_in_check", game_over, 1'b0);
    @(posedge clk);
    @(negedge clk); chk("ovr_done", game_over, 1'b1);
    repeat (4) @(negedge clk);
    sb.push_back(model_snap());
    compare("win_p1");
    repeat (3) act(1, 0, "done_move");
    act(0, 1, "restart");

    // place on an occupied cell is ignored
    place_at(4);
    act(0, 1, "occupied");
    // move and place together: place wins, cursor stays
    goto_cell(5);
    act(1, 1, "mv_pl");

    do_reset("reset2");
    for (int i = 0; i < 9; i++) place_at(fill_order[i]);
    act(1, 0, "draw_move");
    act(0, 1, "draw_clear");
`endif

    // reset asserted while the FSM sits in CHECK
    m_step(0, 1);
    timed_place();
    @(negedge clk); rst_n = 1'b0;
    m_reset();
    sb.push_back(model_snap());
    #1 compare("rst_in_check");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb.push_back(model_snap());
    compare("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
